// File: rtl/spi_slave_regif_if.sv
// Register-bus side of the SPI register interface: address/data/strobes out,
// read data and its valid pulse back from the register file.
interface spi_slave_regif_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] o_bus_addr;
    logic [7:0]        o_bus_wdata;
    logic              o_bus_we;
    logic              o_bus_re;
    logic [7:0]        i_bus_rdata;
    logic              i_bus_rvalid;

    modport master (
        output o_bus_addr, o_bus_wdata, o_bus_we, o_bus_re,
        input  i_bus_rdata, i_bus_rvalid
    );

    modport slave (
        input  o_bus_addr, o_bus_wdata, o_bus_we, o_bus_re,
        output i_bus_rdata, i_bus_rvalid
    );
endinterface

// File: rtl/spi_slave_regif.sv
// Register-access layer behind the SPI slave engine: byte 0 of a frame is {rw, addr},
// following bytes stream to/from the register bus with address auto-increment.
module spi_slave_regif #(
    parameter int         ADDR_W     = 7,
    parameter int         RD_TIMEOUT = 2,
    parameter logic [7:0] TO_DATA    = 8'hFF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_data_valid,
    input  logic               i_wip,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_data_valid,
    input  logic [7:0]         i_status,
    spi_slave_regif_if.master  bus,
    output logic               o_rd_timeout,
    output logic [2:0]         dbg_state
);
    // Bus handshake: o_bus_we / o_bus_re are single-cycle strobes qualified by
    // o_bus_addr (and o_bus_wdata for writes); the register file answers a read
    // with a one-cycle i_bus_rvalid pulse carrying i_bus_rdata, at most RD_TIMEOUT
    // cycles after the cycle o_bus_re is high.

    localparam int CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RD_XFER = 3'd4,
        WR_XFER = 3'd5
    } state_t;

    state_t            state;
    logic              wip_q;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
    logic              wr_fire;

    // A byte already received in a write frame is committed even if i_wip drops with it.
    assign wr_fire   = (state == WR_XFER) && i_rx_data_valid;
    assign dbg_state = state;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= IDLE;
            wip_q           <= 1'b0;
            addr            <= '0;
            cnt             <= '0;
            o_tx_data       <= '0;
            o_tx_data_valid <= 1'b0;
            o_rd_timeout    <= 1'b0;
            bus.o_bus_addr  <= '0;
            bus.o_bus_wdata <= '0;
            bus.o_bus_we    <= 1'b0;
            bus.o_bus_re    <= 1'b0;
        end else begin
            wip_q           <= i_wip;
            o_tx_data_valid <= 1'b0;
            o_rd_timeout    <= 1'b0;
            bus.o_bus_we    <= 1'b0;
            bus.o_bus_re    <= 1'b0;

            if (wr_fire) begin
                bus.o_bus_wdata <= i_rx_data;
                bus.o_bus_addr  <= addr;
                bus.o_bus_we    <= 1'b1;
                addr            <= addr + ADDR_W'(1);
            end

            if (!i_wip) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!wip_q) begin
                            o_tx_data       <= i_status;
                            o_tx_data_valid <= 1'b1;
                            state           <= CMD;
                        end
                    end
                    CMD: begin
                        if (i_rx_data_valid) begin
                            addr <= i_rx_data[ADDR_W-1:0];
                            if (i_rx_data[7]) begin
                                bus.o_bus_addr <= i_rx_data[ADDR_W-1:0];
                                bus.o_bus_re   <= 1'b1;
                                state          <= RD_REQ;
                            end else begin
                                state <= WR_XFER;
                            end
                        end
                    end
                    // o_bus_re is high during this state; the wait window starts next cycle.
                    RD_REQ: begin
                        cnt   <= '0;
                        state <= RD_WAIT;
                    end
                    RD_WAIT: begin
                        if (bus.i_bus_rvalid) begin
                            o_tx_data       <= bus.i_bus_rdata;
                            o_tx_data_valid <= 1'b1;
                            state           <= RD_XFER;
                        end else if (cnt == CNT_LAST) begin
                            o_tx_data       <= TO_DATA;
                            o_tx_data_valid <= 1'b1;
                            o_rd_timeout    <= 1'b1;
                            state           <= RD_XFER;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    RD_XFER: begin
                        if (i_rx_data_valid) begin
                            addr           <= addr + ADDR_W'(1);
                            bus.o_bus_addr <= addr + ADDR_W'(1);
                            bus.o_bus_re   <= 1'b1;
                            state          <= RD_REQ;
                        end
                    end
                    WR_XFER: state <= WR_XFER;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench for spi_slave_regif: per-cycle vector table for write/read/timeout/wrap
// frames, then hand sequences for frame abort during a read and async reset mid-write.
module tb_spi_slave_regif;
    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_rx_data;
    logic       i_rx_data_valid;
    logic       i_wip;
    logic [7:0] o_tx_data;
    logic       o_tx_data_valid;
    logic [7:0] i_status;
    logic       o_rd_timeout;
    logic [2:0] dbg_state;

    spi_slave_regif_if #(.ADDR_W(7)) bus_if ();

    spi_slave_regif #(.ADDR_W(7), .RD_TIMEOUT(2), .TO_DATA(8'hFF)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_rx_data       (i_rx_data),
        .i_rx_data_valid (i_rx_data_valid),
        .i_wip           (i_wip),
        .o_tx_data       (o_tx_data),
        .o_tx_data_valid (o_tx_data_valid),
        .i_status        (i_status),
        .bus             (bus_if),
        .o_rd_timeout    (o_rd_timeout),
        .dbg_state       (dbg_state)
    );

    always #5 i_clk = ~i_clk;

    // One cycle: inputs held during the cycle, expected registered outputs after the edge.
    typedef struct {
        logic       wip;
        logic       rxv;
        logic [7:0] rx;
        logic       rv;
        logic [7:0] rd;
        logic [7:0] st;
        logic       txv;
        logic [7:0] tx;
        logic       we;
        logic       re;
        logic [6:0] addr;
        logic [7:0] wd;
        logic       to;
    } vec_t;

    vec_t        vecs[$];
    logic [26:0] exp_q[$];
    int          total = 0;
    int          bad = 0;

    function automatic vec_t mk(input logic wip, input logic rxv, input logic [7:0] rx,
                                input logic rv, input logic [7:0] rd, input logic [7:0] st,
                                input logic txv, input logic [7:0] tx, input logic we,
                                input logic re, input logic [6:0] addr, input logic [7:0] wd,
                                input logic to);
        vec_t v;
        v.wip = wip; v.rxv = rxv; v.rx = rx; v.rv = rv; v.rd = rd; v.st = st;
        v.txv = txv; v.tx = tx; v.we = we; v.re = re; v.addr = addr; v.wd = wd; v.to = to;
        return v;
    endfunction

    function automatic logic [26:0] outs();
        return {o_tx_data_valid, o_tx_data, bus_if.o_bus_we, bus_if.o_bus_re,
                bus_if.o_bus_addr, bus_if.o_bus_wdata, o_rd_timeout};
    endfunction

    task automatic check(input string name);
        logic [26:0] exp;
        logic [26:0] act;
        act = outs();
        exp = exp_q.pop_front();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {txv,tx,we,re,addr,wd,to}=%h want %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        i_wip           = v.wip;
        i_rx_data_valid = v.rxv;
        i_rx_data       = v.rx;
        bus_if.i_bus_rvalid = v.rv;
        bus_if.i_bus_rdata  = v.rd;
        i_status        = v.st;
        exp_q.push_back({v.txv, v.tx, v.we, v.re, v.addr, v.wd, v.to});
        @(posedge i_clk);
        #1;
        check(name);
    endtask

    initial begin
        i_reset = 1'b1;
        i_wip = 1'b0; i_rx_data_valid = 1'b0; i_rx_data = 8'h00; i_status = 8'h00;
        bus_if.i_bus_rvalid = 1'b0; bus_if.i_bus_rdata = 8'h00;

        // wip rx_v rx rvalid rdata status | tx_v tx we re addr wdata timeout
        // Write frame: status A5, cmd 05, data 11, 22
        vecs.push_back(mk(0,0,8'h00,0,8'h00,8'h00, 0,8'h00,0,0,7'h00,8'h00,0));
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'hA5, 1,8'hA5,0,0,7'h00,8'h00,0));
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'hA5, 0,8'hA5,0,0,7'h00,8'h00,0));
        vecs.push_back(mk(1,1,8'h05,0,8'h00,8'hA5, 0,8'hA5,0,0,7'h00,8'h00,0));
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'hA5, 0,8'hA5,0,0,7'h00,8'h00,0));
        vecs.push_back(mk(1,1,8'h11,0,8'h00,8'hA5, 0,8'hA5,1,0,7'h05,8'h11,0));
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'hA5, 0,8'hA5,0,0,7'h05,8'h11,0));
        vecs.push_back(mk(1,1,8'h22,0,8'h00,8'hA5, 0,8'hA5,1,0,7'h06,8'h22,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,8'hA5, 0,8'hA5,0,0,7'h06,8'h22,0));
        // Read frame: cmd 83, bus answers one cycle after each read strobe
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'h96, 1,8'h96,0,0,7'h06,8'h22,0));
        vecs.push_back(mk(1,1,8'h83,0,8'h00,8'h96, 0,8'h96,0,1,7'h03,8'h22,0));
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'h96, 0,8'h96,0,0,7'h03,8'h22,0));
        vecs.push_back(mk(1,0,8'h00,1,8'h3C,8'h96, 1,8'h3C,0,0,7'h03,8'h22,0));
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'h96, 0,8'h3C,0,0,7'h03,8'h22,0));
        vecs.push_back(mk(1,1,8'h00,0,8'h00,8'h96, 0,8'h3C,0,1,7'h04,8'h22,0));
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'h96, 0,8'h3C,0,0,7'h04,8'h22,0));
        vecs.push_back(mk(1,0,8'h00,1,8'h4D,8'h96, 1,8'h4D,0,0,7'h04,8'h22,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,8'h96, 0,8'h4D,0,0,7'h04,8'h22,0));
        // Timeout at 10, then rvalid on the last allowed cycle at 11
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'h00, 1,8'h00,0,0,7'h04,8'h22,0));
        vecs.push_back(mk(1,1,8'h90,0,8'h00,8'h00, 0,8'h00,0,1,7'h10,8'h22,0));
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'h00, 0,8'h00,0,0,7'h10,8'h22,0));
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'h00, 0,8'h00,0,0,7'h10,8'h22,0));
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'h00, 1,8'hFF,0,0,7'h10,8'h22,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'h00, 0,8'hFF,0,0,7'h10,8'h22,0));
        vecs.push_back(mk(1,1,8'h00,0,8'h00,8'h00, 0,8'hFF,0,1,7'h11,8'h22,0));
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'h00, 0,8'hFF,0,0,7'h11,8'h22,0));
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'h00, 0,8'hFF,0,0,7'h11,8'h22,0));
        vecs.push_back(mk(1,0,8'h00,1,8'h77,8'h00, 1,8'h77,0,0,7'h11,8'h22,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,8'h00, 0,8'h77,0,0,7'h11,8'h22,0));
        // Write with address wrap: cmd 7F, data 01, 02, 03 back to back
        vecs.push_back(mk(1,0,8'h00,0,8'h00,8'hC3, 1,8'hC3,0,0,7'h11,8'h22,0));
        vecs.push_back(mk(1,1,8'h7F,0,8'h00,8'hC3, 0,8'hC3,0,0,7'h11,8'h22,0));
        vecs.push_back(mk(1,1,8'h01,0,8'h00,8'hC3, 0,8'hC3,1,0,7'h7F,8'h01,0));
        vecs.push_back(mk(1,1,8'h02,0,8'h00,8'hC3, 0,8'hC3,1,0,7'h00,8'h02,0));
        vecs.push_back(mk(1,1,8'h03,0,8'h00,8'hC3, 0,8'hC3,1,0,7'h01,8'h03,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,8'hC3, 0,8'hC3,0,0,7'h01,8'h03,0));

        repeat (2) @(posedge i_clk);
        #1;
        exp_q.push_back(27'h0);
        check("reset_outputs");
        total++;
        if (dbg_state !== 3'd0) begin
            bad++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        i_reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Frame dropped while waiting for read data; late rvalid must be ignored
        apply(mk(1,0,8'h00,0,8'h00,8'h3E, 1,8'h3E,0,0,7'h01,8'h03,0), "abort_status");
        apply(mk(1,1,8'h85,0,8'h00,8'h3E, 0,8'h3E,0,1,7'h05,8'h03,0), "abort_re");
        apply(mk(1,0,8'h00,0,8'h00,8'h3E, 0,8'h3E,0,0,7'h05,8'h03,0), "abort_req");
        apply(mk(0,0,8'h00,0,8'h00,8'h3E, 0,8'h3E,0,0,7'h05,8'h03,0), "abort_drop");
        apply(mk(0,0,8'h00,1,8'h99,8'h3E, 0,8'h3E,0,0,7'h05,8'h03,0), "abort_late_rvalid");
        apply(mk(0,0,8'h00,0,8'h00,8'h3E, 0,8'h3E,0,0,7'h05,8'h03,0), "abort_quiet");
        apply(mk(1,0,8'h00,0,8'h00,8'h5B, 1,8'h5B,0,0,7'h05,8'h03,0), "restart_status");
        apply(mk(1,1,8'h02,0,8'h00,8'h5B, 0,8'h5B,0,0,7'h05,8'h03,0), "restart_cmd");
        apply(mk(1,1,8'hAB,0,8'h00,8'h5B, 0,8'h5B,1,0,7'h02,8'hAB,0), "restart_write");
        apply(mk(0,0,8'h00,0,8'h00,8'h5B, 0,8'h5B,0,0,7'h02,8'hAB,0), "restart_end");

        // Async reset while a write strobe is on the bus
        apply(mk(1,0,8'h00,0,8'h00,8'h00, 1,8'h00,0,0,7'h02,8'hAB,0), "rst_status");
        apply(mk(1,1,8'h20,0,8'h00,8'h00, 0,8'h00,0,0,7'h02,8'hAB,0), "rst_cmd");
        apply(mk(1,1,8'h55,0,8'h00,8'h00, 0,8'h00,1,0,7'h20,8'h55,0), "rst_write");
        i_rx_data_valid = 1'b1;
        i_rx_data       = 8'h66;
        i_reset         = 1'b1;
        #1;
        exp_q.push_back(27'h0);
        check("rst_async_immediate");
        @(posedge i_clk);
        #1;
        exp_q.push_back(27'h0);
        check("rst_held");
        i_reset = 1'b0;
        apply(mk(0,1,8'h66,0,8'h00,8'h00, 0,8'h00,0,0,7'h00,8'h00,0), "rst_after1");
        apply(mk(0,1,8'h77,0,8'h00,8'h00, 0,8'h00,0,0,7'h00,8'h00,0), "rst_after2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
